// File: rtl/swd_auth_gate.sv
// -----------------------------------------------------------------------------
// swd_auth_gate
//
// Authentication front-end for the SWD passthrough. The operator host sends an
// unlock command byte (0xA5) followed by KEY_BYTES key bytes over a UART 8N1
// line. If the key matches the build-time KEY, the SWD passthrough is enabled
// for a session that ends on SWCLK inactivity or an explicit revoke byte
// (0x5A). MAX_FAILS consecutive wrong keys trigger a timed lockout during
// which all UART traffic is ignored.
//
// Parameters:
//   CLKS_PER_BIT        clock cycles per UART bit (minimum 4)
//   KEY_BYTES           key length in bytes
//   KEY                 expected key, MSB byte is sent first
//   SESSION_IDLE_CYCLES SWCLK-idle cycles before an open session closes
//   LOCKOUT_CYCLES      lockout duration in cycles
//   MAX_FAILS           consecutive mismatches that trigger lockout
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   uart_rx     asynchronous UART line from the host, idle high
//   swclk_in    asynchronous SWCLK from the probe, activity monitoring only
//   swd_enable  enable to the passthrough stage (high only in OPEN)
//   led_status  copy of swd_enable for the status LED
//   auth_fail   one-cycle pulse per key mismatch
//   locked      high for the duration of a lockout
// -----------------------------------------------------------------------------
module swd_auth_gate #(
    parameter int                     CLKS_PER_BIT        = 104,
    parameter int                     KEY_BYTES           = 4,
    parameter logic [8*KEY_BYTES-1:0] KEY                 = 32'hC0DE_1234,
    parameter int                     SESSION_IDLE_CYCLES = 12_000_000,
    parameter int                     LOCKOUT_CYCLES      = 120_000_000,
    parameter int                     MAX_FAILS           = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    input  logic swclk_in,
    output logic swd_enable,
    output logic led_status,
    output logic auth_fail,
    output logic locked
);

    // -------------------------------------------------------------------------
    // Widths and constants
    // -------------------------------------------------------------------------
    localparam int KEY_W  = 8 * KEY_BYTES;
    localparam int BIT_W  = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDLE_W = $clog2(SESSION_IDLE_CYCLES) + 1;
    localparam int LOCK_W = $clog2(LOCKOUT_CYCLES) + 1;
    localparam int FAIL_W = $clog2(MAX_FAILS) + 1;
    localparam int IDX_W  = $clog2(KEY_BYTES) + 1;

    localparam logic [BIT_W-1:0]  HALF_BIT  = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0]  FULL_BIT  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(SESSION_IDLE_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(KEY_BYTES - 1);

    localparam logic [7:0] CMD_UNLOCK = 8'hA5;
    localparam logic [7:0] CMD_REVOKE = 8'h5A;

    // -------------------------------------------------------------------------
    // Input synchronizers and edge detectors
    // -------------------------------------------------------------------------
    logic uart_meta, uart_s, uart_prev;
    logic swclk_meta, swclk_s, swclk_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_meta  <= 1'b1;
            uart_s     <= 1'b1;
            uart_prev  <= 1'b1;
            swclk_meta <= 1'b0;
            swclk_s    <= 1'b0;
            swclk_prev <= 1'b0;
        end else begin
            uart_meta  <= uart_rx;
            uart_s     <= uart_meta;
            uart_prev  <= uart_s;
            swclk_meta <= swclk_in;
            swclk_s    <= swclk_meta;
            swclk_prev <= swclk_s;
        end
    end

    logic uart_fall;
    logic swclk_rise;

    assign uart_fall  = uart_prev & ~uart_s;
    assign swclk_rise = swclk_s & ~swclk_prev;

    // -------------------------------------------------------------------------
    // UART 8N1 receiver
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t        rx_state, rx_state_d;
    logic [BIT_W-1:0] rx_cnt, rx_cnt_d;
    logic [2:0]       rx_bit_idx, rx_bit_idx_d;
    logic [7:0]       rx_shift, rx_shift_d;
    logic             rx_valid, rx_valid_d;
    logic             frame_err, frame_err_d;
    logic [7:0]       rx_byte;

    // The shift register is only touched during data bits, so it still holds
    // the completed byte in the cycle rx_valid is high.
    assign rx_byte = rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            rx_cnt     <= '0;
            rx_bit_idx <= '0;
            rx_shift   <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit_idx <= rx_bit_idx_d;
            rx_shift   <= rx_shift_d;
            rx_valid   <= rx_valid_d;
            frame_err  <= frame_err_d;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a default first, otherwise the
        // paths that leave it untouched would infer a latch.
        rx_state_d   = rx_state;
        rx_cnt_d     = rx_cnt;
        rx_bit_idx_d = rx_bit_idx;
        rx_shift_d   = rx_shift;
        rx_valid_d   = 1'b0;
        frame_err_d  = 1'b0;

        unique case (rx_state)
            RX_IDLE: begin
                if (uart_fall) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end

            // Mid-bit check of the start bit filters glitches on the line.
            RX_START: begin
                if (rx_cnt == HALF_BIT) begin
                    rx_cnt_d     = '0;
                    rx_bit_idx_d = '0;
                    rx_state_d   = uart_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt + BIT_W'(1);
                end
            end

            RX_DATA: begin
                if (rx_cnt == FULL_BIT) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {uart_s, rx_shift[7:1]};   // LSB arrives first
                    if (rx_bit_idx == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_idx_d = rx_bit_idx + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt + BIT_W'(1);
                end
            end

            RX_STOP: begin
                if (rx_cnt == FULL_BIT) begin
                    rx_cnt_d    = '0;
                    rx_state_d  = RX_IDLE;
                    rx_valid_d  = uart_s;
                    frame_err_d = ~uart_s;
                end else begin
                    rx_cnt_d = rx_cnt + BIT_W'(1);
                end
            end

            default: rx_state_d = RX_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_KEY,
        ST_CHECK,
        ST_OPEN,
        ST_LOCKED
    } state_t;

    state_t            state, state_d;
    logic [KEY_W-1:0]  key_sr, key_sr_d;
    logic [IDX_W-1:0]  byte_idx, byte_idx_d;
    logic [FAIL_W-1:0] fail_cnt, fail_cnt_d;
    logic [FAIL_W-1:0] fail_next;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_d;
    logic [LOCK_W-1:0] lock_cnt, lock_cnt_d;
    logic              auth_fail_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_sr    <= '0;
            byte_idx  <= '0;
            fail_cnt  <= '0;
            idle_cnt  <= '0;
            lock_cnt  <= '0;
            auth_fail <= 1'b0;
        end else begin
            state     <= state_d;
            key_sr    <= key_sr_d;
            byte_idx  <= byte_idx_d;
            fail_cnt  <= fail_cnt_d;
            idle_cnt  <= idle_cnt_d;
            lock_cnt  <= lock_cnt_d;
            auth_fail <= auth_fail_d;
        end
    end

    always_comb begin
        state_d     = state;
        key_sr_d    = key_sr;
        byte_idx_d  = byte_idx;
        fail_cnt_d  = fail_cnt;
        idle_cnt_d  = idle_cnt;
        lock_cnt_d  = lock_cnt;
        auth_fail_d = 1'b0;
        fail_next   = fail_cnt + FAIL_W'(1);

        unique case (state)
            ST_IDLE: begin
                if (rx_valid && rx_byte == CMD_UNLOCK) begin
                    state_d    = ST_KEY;
                    byte_idx_d = '0;
                    key_sr_d   = '0;
                end
            end

            // Every byte here is key material, including 0xA5. A corrupted
            // frame abandons the attempt without charging a failure, since a
            // line error says nothing about whether the host knows the key.
            ST_KEY: begin
                if (frame_err) begin
                    state_d = ST_IDLE;
                end else if (rx_valid) begin
                    key_sr_d = (key_sr << 8) | KEY_W'(rx_byte);
                    if (byte_idx == LAST_IDX) begin
                        state_d = ST_CHECK;
                    end else begin
                        byte_idx_d = byte_idx + IDX_W'(1);
                    end
                end
            end

            ST_CHECK: begin
                if (key_sr == KEY) begin
                    state_d    = ST_OPEN;
                    fail_cnt_d = '0;
                    idle_cnt_d = IDLE_LOAD;
                end else begin
                    auth_fail_d = 1'b1;
                    if (fail_next == FAIL_MAX) begin
                        state_d    = ST_LOCKED;
                        lock_cnt_d = LOCK_LOAD;
                        fail_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                        fail_cnt_d = fail_next;
                    end
                end
            end

            // Priority: revoke, then SWCLK activity, then timeout. An edge in
            // the same cycle the counter would expire keeps the session open.
            ST_OPEN: begin
                if (rx_valid && rx_byte == CMD_REVOKE) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end else if (swclk_rise) begin
                    idle_cnt_d = IDLE_LOAD;
                end else if (idle_cnt <= IDLE_W'(1)) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt - IDLE_W'(1);
                end
            end

            // Leaving when the counter steps from 1 to 0 keeps 'locked' high
            // for exactly LOCKOUT_CYCLES cycles.
            ST_LOCKED: begin
                if (lock_cnt <= LOCK_W'(1)) begin
                    state_d    = ST_IDLE;
                    lock_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt - LOCK_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from the registered state so they are glitch-free
    // -------------------------------------------------------------------------
    assign swd_enable = (state == ST_OPEN);
    assign led_status = swd_enable;
    assign locked     = (state == ST_LOCKED);

endmodule
